// File: rtl/alu_pipe.sv
// Registered, handshaked RV32I integer execution unit (RS -> CDB) with flush and global pause.
// Define ALU_MUL_EN to add the iterative radix-2 multiplier for MUL/MULH/MULHSU/MULHU.
module alu_pipe #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clr_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_val1,
  input  logic [XLEN-1:0]  in_val2,
  input  logic [ROB_W-1:0] in_rob,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_ans,
  output logic [ROB_W-1:0] out_rob,
  output logic [OP_W-1:0]  out_op
);

  localparam int SH_W = $clog2(XLEN);

  // Opcode encodings mirror defines.v.
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(20);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(24);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(25);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(26);

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_ans_q, out_ans_d;
  logic [ROB_W-1:0] out_rob_q, out_rob_d;
  logic [OP_W-1:0]  out_op_q, out_op_d;

  logic [SH_W-1:0]  shamt;
  logic [XLEN-1:0]  alu_ans;
  logic             idle;
  logic             accept;

  assign shamt = in_val2[SH_W-1:0];

  always_comb begin
    alu_ans = '0;
    case (in_op)
      OP_ADD, OP_ADDI, OP_JALR: alu_ans = in_val1 + in_val2;
      OP_SUB:                   alu_ans = in_val1 - in_val2;
      OP_XOR, OP_XORI:          alu_ans = in_val1 ^ in_val2;
      OP_OR, OP_ORI:            alu_ans = in_val1 | in_val2;
      OP_AND, OP_ANDI:          alu_ans = in_val1 & in_val2;
      OP_SLL, OP_SLLI:          alu_ans = in_val1 << shamt;
      OP_SRL, OP_SRLI:          alu_ans = in_val1 >> shamt;
      OP_SRA, OP_SRAI:          alu_ans = $unsigned($signed(in_val1) >>> shamt);
      OP_SLT, OP_SLTI, OP_BLT:  alu_ans = XLEN'($signed(in_val1) < $signed(in_val2));
      OP_SLTU, OP_SLTIU, OP_BLTU: alu_ans = XLEN'(in_val1 < in_val2);
      OP_BEQ:                   alu_ans = XLEN'(in_val1 == in_val2);
      OP_BNE:                   alu_ans = XLEN'(in_val1 != in_val2);
      OP_BGE:                   alu_ans = XLEN'(!($signed(in_val1) < $signed(in_val2)));
      OP_BGEU:                  alu_ans = XLEN'(!(in_val1 < in_val2));
      default:                  alu_ans = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(27);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(28);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(29);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(30);

  localparam logic [0:0]    S_IDLE    = 1'b0;
  localparam logic [0:0]    S_MUL     = 1'b1;
  localparam logic [SH_W:0] MUL_ITERS = (SH_W+1)'(XLEN);

  logic [0:0]       state_q, state_d;
  logic [SH_W:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [OP_W-1:0]  mop_q, mop_d;
  logic [ROB_W-1:0] mrob_q, mrob_d;

  logic             is_mul_op;
  logic             sgn1, sgn2;
  logic [XLEN-1:0]  mag1, mag2;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]  mul_ans;

  assign is_mul_op = (in_op == OP_MUL) || (in_op == OP_MULH) ||
                     (in_op == OP_MULHSU) || (in_op == OP_MULHU);
  assign sgn1 = ((in_op == OP_MUL) || (in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_val1[XLEN-1];
  assign sgn2 = ((in_op == OP_MUL) || (in_op == OP_MULH)) && in_val2[XLEN-1];
  assign mag1 = sgn1 ? (-in_val1) : in_val1;
  assign mag2 = sgn2 ? (-in_val2) : in_val2;
  assign prod = neg_q ? (-acc_q) : acc_q;
  assign mul_ans = (mop_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign idle = (state_q == S_IDLE);
`else
  assign idle = 1'b1;
`endif

  assign in_ready = rst_in && rdy_in && !clr_in && idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_ans_d   = out_ans_q;
    out_rob_d   = out_rob_q;
    out_op_d    = out_op_q;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    mop_d    = mop_q;
    mrob_d   = mrob_q;
`endif
    if (clr_in) begin
      out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
      state_d  = S_IDLE;
      cnt_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      acc_d    = '0;
      neg_d    = 1'b0;
`endif
    end else if (rdy_in) begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
      if (accept && is_mul_op) begin
        state_d  = S_MUL;
        cnt_d    = '0;
        mcand_d  = {{XLEN{1'b0}}, mag1};
        mplier_d = mag2;
        acc_d    = '0;
        neg_d    = sgn1 ^ sgn2;
        mop_d    = in_op;
        mrob_d   = in_rob;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_ans_d   = alu_ans;
        out_rob_d   = in_rob;
        out_op_d    = in_op;
      end else if (state_q == S_MUL) begin
        // One extra edge after the last iteration applies the sign and publishes.
        if (cnt_q == MUL_ITERS) begin
          out_valid_d = 1'b1;
          out_ans_d   = mul_ans;
          out_rob_d   = mrob_q;
          out_op_d    = mop_q;
          state_d     = S_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
`else
      if (accept) begin
        out_valid_d = 1'b1;
        out_ans_d   = alu_ans;
        out_rob_d   = in_rob;
        out_op_d    = in_op;
      end
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      out_valid_q <= 1'b0;
      out_ans_q   <= '0;
      out_rob_q   <= '0;
      out_op_q    <= '0;
`ifdef ALU_MUL_EN
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      mop_q    <= '0;
      mrob_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_ans_q   <= out_ans_d;
      out_rob_q   <= out_rob_d;
      out_op_q    <= out_op_d;
`ifdef ALU_MUL_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      mop_q    <= mop_d;
      mrob_q   <= mrob_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_ans   = out_ans_q;
  assign out_rob   = out_rob_q;
  assign out_op    = out_op_q;

endmodule
